// File: rtl/char_rom_arbiter.sv
// Two-client arbiter for the shared combinational character ROM port.
// Registers the ROM address, then returns the code with a requester tag two edges after the grant.
module char_rom_arbiter #(
  parameter bit          PRIO0        = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] xy0,
  input  logic       req1,
  input  logic [7:0] xy1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [7:0] rom_xy,
  input  logic [6:0] rom_code,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [6:0] rsp_code
);

  localparam int unsigned XY_W   = 8;
  localparam int unsigned CODE_W = 7;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CODE_W-1:0] BLANK   = CODE_W'(7'h20);

  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              last_q, last_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_id_q, s1_id_d;
  logic [XY_W-1:0]   rom_xy_q, rom_xy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [CODE_W-1:0] rsp_code_q, rsp_code_d;
  logic              pick1;

  // Contention winner: starvation guard in priority mode, least-recently-granted otherwise.
  always_comb begin
    pick1 = 1'b0;
    if (PRIO0) begin
      pick1 = (starve_cnt_q == LIMIT);
    end else begin
      pick1 = ~last_q;
    end
    gnt0 = rst_n & req0 & (~req1 | ~pick1);
    gnt1 = rst_n & req1 & (~req0 | pick1);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    last_d       = last_q;
    s1_valid_d   = gnt0 | gnt1;
    s1_id_d      = s1_id_q;
    rom_xy_d     = rom_xy_q;
    rsp_valid_d  = s1_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_code_d   = rsp_code_q;

    if (!req1 || gnt1) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    if (gnt1) begin
      last_d   = 1'b1;
      s1_id_d  = 1'b1;
      rom_xy_d = xy1;
    end else if (gnt0) begin
      last_d   = 1'b0;
      s1_id_d  = 1'b0;
      rom_xy_d = xy0;
    end

    // Response fields only move when stage 1 carries a lookup; otherwise they hold.
    if (s1_valid_q) begin
      rsp_code_d = rom_code;
      rsp_id_d   = s1_id_q;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      last_q       <= 1'b1;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= 1'b0;
      rom_xy_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_code_q   <= BLANK;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      last_q       <= last_d;
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      rom_xy_q     <= rom_xy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_code_q   <= rsp_code_d;
    end
  end

  assign rom_xy    = rom_xy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_code  = rsp_code_q;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Scoreboard bench for char_rom_arbiter: a priority instance and a round-robin instance share stimulus.
module tb_char_rom_arbiter;

  localparam int unsigned LIMIT = 4;

  typedef struct packed {
    logic        id;
    logic [6:0]  code;
    logic [31:0] due;
  } exp_t;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] xy0, xy1;

  logic       p_gnt0, p_gnt1, p_rsp_valid, p_rsp_id;
  logic [7:0] p_rom_xy;
  logic [6:0] p_rom_code, p_rsp_code;
  logic       r_gnt0, r_gnt1, r_rsp_valid, r_rsp_id;
  logic [7:0] r_rom_xy;
  logic [6:0] r_rom_code, r_rsp_code;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned starve[2];
  logic        last[2];

  // Character ROM contents: "Start" then blanks.
  function automatic logic [6:0] rom_f(input logic [7:0] a);
    case (a)
      8'h00:   return 7'h53;
      8'h01:   return 7'h74;
      8'h02:   return 7'h61;
      8'h03:   return 7'h72;
      8'h04:   return 7'h74;
      default: return 7'h20;
    endcase
  endfunction

  assign p_rom_code = rom_f(p_rom_xy);
  assign r_rom_code = rom_f(r_rom_xy);

  char_rom_arbiter #(.PRIO0(1'b1), .STARVE_LIMIT(LIMIT)) u_prio (
    .pclk(pclk), .rst_n(rst_n), .req0(req0), .xy0(xy0), .req1(req1), .xy1(xy1),
    .gnt0(p_gnt0), .gnt1(p_gnt1), .rom_xy(p_rom_xy), .rom_code(p_rom_code),
    .rsp_valid(p_rsp_valid), .rsp_id(p_rsp_id), .rsp_code(p_rsp_code)
  );

  char_rom_arbiter #(.PRIO0(1'b0), .STARVE_LIMIT(LIMIT)) u_rr (
    .pclk(pclk), .rst_n(rst_n), .req0(req0), .xy0(xy0), .req1(req1), .xy1(xy1),
    .gnt0(r_gnt0), .gnt1(r_gnt1), .rom_xy(r_rom_xy), .rom_code(r_rom_code),
    .rsp_valid(r_rsp_valid), .rsp_id(r_rsp_id), .rsp_code(r_rsp_code)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: decides the expected grant for the coming edge and queues the response.
  task automatic model_step(input int i, input logic g0, input logic g1, input logic rv,
                            input logic rid, input logic [7:0] rxy, input logic [6:0] rcode);
    logic w0, w1, zero_wins;
    exp_t e;
    string tag;
    tag = (i == 0) ? "prio" : "rr";
    if (!rst_n) begin
      chk({tag, " rst gnt0"}, 32'(g0), 32'd0);
      chk({tag, " rst gnt1"}, 32'(g1), 32'd0);
      chk({tag, " rst rom_xy"}, 32'(rxy), 32'h00);
      chk({tag, " rst rsp_valid"}, 32'(rv), 32'd0);
      chk({tag, " rst rsp_id"}, 32'(rid), 32'd0);
      chk({tag, " rst rsp_code"}, 32'(rcode), 32'h20);
      starve[i] = 0;
      last[i]   = 1'b1;
      if (i == 0) q0.delete(); else q1.delete();
      return;
    end
    if (i == 0) zero_wins = (starve[i] != LIMIT);
    else        zero_wins = (last[i] == 1'b1);
    w0 = req0 && (!req1 || zero_wins);
    w1 = req1 && !w0;
    chk({tag, " gnt0"}, 32'(g0), 32'(w0));
    chk({tag, " gnt1"}, 32'(g1), 32'(w1));
    if (w0 || w1) begin
      e.id   = w1;
      e.code = rom_f(w1 ? xy1 : xy0);
      e.due  = cyc + 2;
      if (i == 0) q0.push_back(e); else q1.push_back(e);
      last[i] = w1;
    end
    if (!req1 || w1) starve[i] = 0;
    else if (starve[i] < 255) starve[i] = starve[i] + 1;
  endtask

  always @(negedge pclk) begin
    model_step(0, p_gnt0, p_gnt1, p_rsp_valid, p_rsp_id, p_rom_xy, p_rsp_code);
    model_step(1, r_gnt0, r_gnt1, r_rsp_valid, r_rsp_id, r_rom_xy, r_rsp_code);
  end

  // Monitor: pops the oldest expected response whenever a DUT presents one.
  always @(negedge pclk) begin
    exp_t e;
    if (p_rsp_valid) begin
      if (q0.size() == 0) chk("prio unexpected rsp_valid", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("prio rsp_id", 32'(p_rsp_id), 32'(e.id));
        chk("prio rsp_code", 32'(p_rsp_code), 32'(e.code));
        chk("prio latency", cyc, e.due);
      end
    end
    if (r_rsp_valid) begin
      if (q1.size() == 0) chk("rr unexpected rsp_valid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("rr rsp_id", 32'(r_rsp_id), 32'(e.id));
        chk("rr rsp_code", 32'(r_rsp_code), 32'(e.code));
        chk("rr latency", cyc, e.due);
      end
    end
  end

  task automatic drive(input logic r0, input logic [7:0] x0, input logic r1, input logic [7:0] x1);
    @(posedge pclk);
    #1;
    req0 = r0; xy0 = x0; req1 = r1; xy1 = x1;
  endtask

  task automatic do_reset(input int n);
    @(posedge pclk);
    #1;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; xy0 = '0; xy1 = '0;
    repeat (3) @(posedge pclk);
    #1;
    rst_n = 1'b1;

    // Single lookups
    drive(1'b1, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 1'b1, 8'h03);
    repeat (4) drive(1'b0, 8'h00, 1'b0, 8'h00);

    // Streaming requester 0
    for (int k = 0; k < 6; k++) drive(1'b1, 8'(k), 1'b0, 8'h00);
    repeat (4) drive(1'b0, 8'h00, 1'b0, 8'h00);

    // Contention from a fresh reset: starvation guard and round-robin alternation
    do_reset(2);
    for (int k = 0; k < 15; k++) drive(1'b1, 8'(k % 6), 1'b1, 8'((k + 3) % 6));
    drive(1'b0, 8'h00, 1'b1, 8'h01);
    drive(1'b0, 8'h00, 1'b1, 8'h02);
    repeat (4) drive(1'b0, 8'h00, 1'b0, 8'h00);

    // Out-of-table address with concurrent requester 0
    for (int k = 0; k < 6; k++) drive(1'b1, 8'h02, 1'b1, 8'hFF);
    repeat (4) drive(1'b0, 8'h00, 1'b0, 8'h00);

    // Reset with lookups in flight
    drive(1'b1, 8'h01, 1'b0, 8'h00);
    do_reset(3);
    repeat (5) drive(1'b0, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) drive(1'b1, 8'(k), 1'b1, 8'h04);
    do_reset(3);
    repeat (5) drive(1'b0, 8'h00, 1'b0, 8'h00);

    // Randomized traffic with occasional resets
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        drive($urandom_range(0, 3) != 0, 8'($urandom_range(0, 7)),
              $urandom_range(0, 2) != 0,
              ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)));
      end
    end

    repeat (6) drive(1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge pclk);
    #1;
    chk("prio drained", 32'(q0.size()), 32'd0);
    chk("rr drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/char_rom_arbiter.md
# char_rom_arbiter

Shares the single combinational `char_rom` lookup port (8-bit `char_xy` in, 7-bit `char_code` out) between two text clients: requester 0 is the VGA text-overlay renderer and requester 1 is the game-status/message writer. The block arbitrates with a valid/grant handshake, drives the ROM address from a register, and returns the looked-up code with a requester tag after a fixed two-cycle latency. It sits between the text clients and `char_rom` in the pixel-clock domain.

## Interface
- `PRIO0`, default 1: 1 = requester 0 has fixed priority with starvation guard; 0 = round-robin.
- `STARVE_LIMIT`, default 4: used when `PRIO0`=1. Requester 1 wins after this many consecutive lost cycles. Legal range 1..255.
- `pclk` input 1: pixel clock, single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` input 1: requester 0 wants a lookup this cycle.
- `xy0` input 8: requester 0 character position.
- `req1` input 1: requester 1 wants a lookup this cycle.
- `xy1` input 8: requester 1 character position.
- `gnt0` output 1: combinational. Requester 0 transfer completes at this clock edge.
- `gnt1` output 1: combinational. Requester 1 transfer completes at this clock edge.
- `rom_xy` output 8: registered address to `char_rom.char_xy`.
- `rom_code` input 7: `char_rom.char_code`, combinational from `rom_xy`.
- `rsp_valid` output 1: `rsp_code`/`rsp_id` valid this cycle (one-cycle pulse per transfer).
- `rsp_id` output 1: requester that owns the response.
- `rsp_code` output 7: returned character code.

## Operation
- Transfer: a transfer occurs on a rising edge where `req_k` && `gnt_k`. At most one grant per cycle; `gnt0` && `gnt1` is never true.
- `gnt_k` is a function of `req0`, `req1`, and the registered arbitration state only. A requester that holds `req_k` high is served once per winning cycle (streaming). `xy_k` is sampled only at the transfer edge.
- Only one requester active: it is granted every cycle.
- PRIO0=1, both requesting:
  - 0 wins unless `starve_cnt` == `STARVE_LIMIT`, in which case 1 wins.
  - `starve_cnt` is 8 bits. It increments on each edge where `req1` is high and `gnt1` is low.
  - It clears on any edge where `gnt1` is high or `req1` is low.
  - It saturates at 255.
- PRIO0=0, both requesting: the winner is the requester not granted most recently. The `last` pointer is updated on every transfer and resets to 1, so 0 wins the first contention.
- Pipeline stage 1: on the transfer edge, `rom_xy` <= winning `xy`, the stage-1 valid flag is set, and stage-1 id <= winner.
- Pipeline stage 2: on the next edge, `rsp_code` <= `rom_code`, `rsp_id` <= stage-1 id, and `rsp_valid` <= stage-1 valid.
- No transfer: stage-1 valid clears, `rom_xy` holds its value, and `rsp_code` holds its last value. Only `rsp_valid` drops.
- No backpressure on the response side: clients must accept `rsp_valid` whenever it pulses.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `gnt0`=`gnt1`=0 (forced).
  - `rom_xy`=8'h00, `rsp_valid`=0, `rsp_id`=0, `rsp_code`=7'h20.
  - `starve_cnt`=0, `last`=1, stage-1 valid=0.
- Latency: transfer at edge T → `rsp_valid`=1 in the cycle following edge T+1, for exactly one cycle. This is 2 edges from transfer to response registered.
- Throughput: one transfer per cycle. Back-to-back transfers produce back-to-back `rsp_valid` cycles, in grant order.
- Simultaneous `req0`/`req1` rising in the same cycle: resolved by the arbitration rules above, with no lost request. The loser keeps `req` high and is served later.
- Requester dropping `req` before its grant: no transfer. `starve_cnt` clears if it was requester 1.
- Reset asserted mid-stream: in-flight stage-1/stage-2 contents are discarded. No `rsp_valid` pulse is produced for transfers before reset, even after `rst_n` rises.
- First edge after `rst_n` rises: normal arbitration, with `last`=1 and `starve_cnt`=0.

## Test plan
- Single lookups: `req0` pulse with `xy0`=8'h00 → `rsp_valid` 2 edges later, `rsp_id`=0, `rsp_code`=7'h53. Then `req1` pulse with `xy1`=8'h03 → `rsp_id`=1, `rsp_code`=7'h72.
- Streaming: `req0` held for 6 cycles with `xy0`=00..05 → 6 consecutive `rsp_valid` cycles with codes 53, 74, 61, 72, 74, 20 and `rsp_id`=0.
- Starvation guard (PRIO0=1, STARVE_LIMIT=4): both reqs held 15 cycles → grant sequence 0,0,0,0,1,0,0,0,0,1,0,0,0,0,1. Response ids follow the same order, delayed 2 cycles.
- Round-robin (PRIO0=0): both reqs held 6 cycles after reset → grants 0,1,0,1,0,1. Then `req1` alone for 2 cycles → grants 1,1.
- Reset mid-stream: assert `rst_n`=0 one cycle after a transfer, release 3 cycles later → all outputs at reset values during reset. No `rsp_valid` pulse afterwards until a new transfer occurs.
- Out-of-table address: `xy1`=8'hFF → `rsp_code`=7'h20, `rsp_id`=1. A concurrent `req0` is delayed only per the arbitration rules.
